ahb_apb_bridge: RTL and testbench

//  Single-slave AHB-Lite to APB4 bridge in the uncore.

---
 rtl/ahb_apb_bridge.sv | 109 ++++++++++
 tb/tb_ahb_apb_bridge.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_apb_bridge.sv
// Single-slave AHB-Lite to APB4 bridge: each selected AHB transfer becomes one
// APB SETUP+ACCESS sequence, with back-to-back acceptance in the final ACCESS cycle.
module ahb_apb_bridge #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                HSEL,
    input  logic [ADDR_W-1:0]   HADDR,
    input  logic [1:0]          HTRANS,
    input  logic                HWRITE,
    input  logic                HREADY,
    input  logic [XLEN-1:0]     HWDATA,
    input  logic [XLEN/8-1:0]   HWSTRB,
    output logic [XLEN-1:0]     HRDATA,
    output logic                HREADYOUT,
    output logic                HRESP,
    output logic                PSEL,
    output logic                PENABLE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic                PWRITE,
    output logic [XLEN-1:0]     PWDATA,
    output logic [XLEN/8-1:0]   PSTRB,
    input  logic [XLEN-1:0]     PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, ERR1, ERR2} state_t;

    state_t state;
    state_t nxt;
    logic   accept;
    logic   load;
    logic   hready_q;
    logic   htrans_unused;

    // SEQ and NONSEQ are treated alike; only the "active transfer" bit matters.
    assign htrans_unused = HTRANS[0];
    assign accept        = HSEL & HTRANS[1] & HREADY;

    always_comb begin
        nxt  = state;
        load = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    nxt  = SETUP;
                    load = 1'b1;
                end
            end
            SETUP: nxt = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        nxt = ERR1;
                    end else if (accept) begin
                        nxt  = SETUP;
                        load = 1'b1;
                    end else begin
                        nxt = IDLE;
                    end
                end
            end
            ERR1: nxt = ERR2;
            ERR2: begin
                if (accept) begin
                    nxt  = SETUP;
                    load = 1'b1;
                end else begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change cleanly on the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            HRESP    <= 1'b0;
            hready_q <= 1'b1;
            PADDR    <= '0;
            PWRITE   <= 1'b0;
        end else begin
            state    <= nxt;
            PSEL     <= (nxt == SETUP) || (nxt == ACCESS);
            PENABLE  <= (nxt == ACCESS);
            HRESP    <= (nxt == ERR1) || (nxt == ERR2);
            hready_q <= (nxt == IDLE) || (nxt == ERR2);
            if (load) begin
                PADDR  <= HADDR;
                PWRITE <= HWRITE;
            end
        end
    end

    // In ACCESS the slave's handshake is reflected straight back to the master;
    // an error completion is held off so the two-cycle ERROR response can follow.
    assign HREADYOUT = (state == ACCESS) ? (PREADY & ~PSLVERR) : hready_q;
    assign HRDATA    = ((state == ACCESS) && !PWRITE) ? PRDATA : '0;
    assign PWDATA    = HWDATA;
    assign PSTRB     = PWRITE ? HWSTRB : '0;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Self-checking bench for ahb_apb_bridge: directed AHB transfers with an APB
// completion scoreboard plus cycle-level protocol checks.
module tb_ahb_apb_bridge;

    localparam int XLEN   = 64;
    localparam int ADDR_W = 16;

    logic              clk;
    logic              reset;
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic              HREADY;
    logic [XLEN-1:0]   HWDATA;
    logic [XLEN/8-1:0] HWSTRB;
    logic [XLEN-1:0]   HRDATA;
    logic              HREADYOUT;
    logic              HRESP;
    logic              PSEL;
    logic              PENABLE;
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic [XLEN-1:0]   PWDATA;
    logic [XLEN/8-1:0] PSTRB;
    logic [XLEN-1:0]   PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [XLEN-1:0]   wdata;
        logic [XLEN/8-1:0] strb;
        logic [XLEN-1:0]   rdata;
        logic              err;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;
    int  n_checks = 0;
    int  n_fail   = 0;

    ahb_apb_bridge #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HREADY(HREADY), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    // Single-slave system: the global ready is this bridge's own ready.
    assign HREADY = HREADYOUT;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // APB completion monitor: every completed APB transfer must match the queue head.
    always @(negedge clk) begin
        if (!reset && PSEL && PENABLE && PREADY) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_paddr", PADDR, mon_e.addr);
                chk("sb_pwrite", PWRITE, mon_e.wr);
                chk("sb_pslverr", PSLVERR, mon_e.err);
                chk("sb_pstrb", PSTRB, mon_e.strb);
                if (mon_e.wr) chk("sb_pwdata", PWDATA, mon_e.wdata);
                else          chk("sb_hrdata", HRDATA, mon_e.rdata);
            end
        end
    end

    task automatic ahb_xfer(input logic [ADDR_W-1:0] addr, input logic wr,
                            input logic [XLEN-1:0] wdata, input logic [XLEN/8-1:0] strb,
                            input logic [XLEN-1:0] rdata, input int waits, input logic err);
        sb_t e;
        @(posedge clk); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = rdata;
        e.addr = addr; e.wr = wr; e.wdata = wdata; e.strb = wr ? strb : '0;
        e.rdata = rdata; e.err = err;
        sb.push_back(e);
        @(posedge clk); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = ~addr;
        HWDATA = wdata; HWSTRB = strb;
        @(negedge clk);
        chk("setup_psel", PSEL, 1);
        chk("setup_penable", PENABLE, 0);
        chk("setup_hreadyout", HREADYOUT, 0);
        chk("setup_paddr", PADDR, addr);
        chk("setup_pstrb", PSTRB, wr ? strb : '0);
        for (int i = 0; i <= waits; i++) begin
            @(posedge clk); #1;
            if (i == waits) begin
                PREADY = 1'b1; PSLVERR = err;
            end
            @(negedge clk);
            chk("acc_psel", PSEL, 1);
            chk("acc_penable", PENABLE, 1);
            chk("acc_paddr", PADDR, addr);
            chk("acc_pwrite", PWRITE, wr);
            chk("acc_hreadyout", HREADYOUT, (i == waits) && !err);
            chk("acc_hresp", HRESP, 0);
            if (wr) chk("acc_pwdata", PWDATA, wdata);
            else    chk("acc_hrdata", HRDATA, rdata);
        end
        @(posedge clk); #1;
        PREADY = 1'b0; PSLVERR = 1'b0;
        if (err) begin
            @(negedge clk);
            chk("err1_hresp", HRESP, 1);
            chk("err1_hreadyout", HREADYOUT, 0);
            chk("err1_psel", PSEL, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("err2_hresp", HRESP, 1);
            chk("err2_hreadyout", HREADYOUT, 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("idle_psel", PSEL, 0);
        chk("idle_penable", PENABLE, 0);
        chk("idle_hresp", HRESP, 0);
        chk("idle_hreadyout", HREADYOUT, 1);
        chk("idle_hrdata", HRDATA, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
        HWDATA = '0; HWSTRB = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        @(posedge clk); #1;
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_hreadyout", HREADYOUT, 1);
        chk("rst_hresp", HRESP, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // T1 write, T2 read, T3 wait states
        ahb_xfer(16'h4000, 1'b1, 64'h0000_0000_0000_0100, 8'hFF, 64'h0, 0, 1'b0);
        ahb_xfer(16'hBFF8, 1'b0, 64'hDEAD_BEEF_0000_0001, 8'hFF, 64'h1234, 0, 1'b0);
        ahb_xfer(16'h0010, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0, 8'h3C, 64'h0, 3, 1'b0);
        ahb_xfer(16'h0020, 1'b0, 64'h0, 8'h0F, 64'hCAFE_F00D_1357_9BDF, 2, 1'b0);

        // T4 back-to-back: write 0x0000 then read 0x4000 with no IDLE gap
        @(posedge clk); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 16'h0000; HWRITE = 1'b1;
        PREADY = 1'b0; PRDATA = 64'h0;
        sb.push_back('{16'h0000, 1'b1, 64'h1111_2222_3333_4444, 8'h0F, 64'h0, 1'b0});
        sb.push_back('{16'h4000, 1'b0, 64'h0, 8'h00, 64'h5555_6666_7777_8888, 1'b0});
        @(posedge clk); #1;
        HADDR = 16'h4000; HWRITE = 1'b0; HTRANS = 2'b10;
        HWDATA = 64'h1111_2222_3333_4444; HWSTRB = 8'h0F; PREADY = 1'b1;
        @(negedge clk);
        chk("b2b_setup1_psel", PSEL, 1);
        chk("b2b_setup1_paddr", PADDR, 16'h0000);
        @(negedge clk);
        chk("b2b_access1_penable", PENABLE, 1);
        chk("b2b_access1_hreadyout", HREADYOUT, 1);
        @(posedge clk); #1;
        HSEL = 1'b0; HTRANS = 2'b00; PRDATA = 64'h5555_6666_7777_8888;
        @(negedge clk);
        chk("b2b_setup2_psel", PSEL, 1);
        chk("b2b_setup2_penable", PENABLE, 0);
        chk("b2b_setup2_paddr", PADDR, 16'h4000);
        chk("b2b_setup2_pwrite", PWRITE, 0);
        chk("b2b_setup2_pstrb", PSTRB, 0);
        @(negedge clk);
        chk("b2b_access2_hrdata", HRDATA, 64'h5555_6666_7777_8888);
        @(negedge clk);
        chk("b2b_idle_psel", PSEL, 0);
        PREADY = 1'b0;

        // T5 slave error on a read
        ahb_xfer(16'h0ABC, 1'b0, 64'h0, 8'h00, 64'h0BAD, 1, 1'b1);
        ahb_xfer(16'h0100, 1'b1, 64'h0000_0000_FFFF_0000, 8'hF0, 64'h0, 0, 1'b0);

        // T6 reset during a stalled ACCESS
        @(posedge clk); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 16'h7777; HWRITE = 1'b1; PREADY = 1'b0;
        @(posedge clk); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_pre_penable", PENABLE, 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_psel", PSEL, 0);
        chk("t6_rst_penable", PENABLE, 0);
        chk("t6_rst_hreadyout", HREADYOUT, 1);
        chk("t6_rst_paddr", PADDR, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        HSEL = 1'b1; HTRANS = 2'b00; HADDR = 16'h1234; HWRITE = 1'b1; PREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_idle_psel", PSEL, 0);
            chk("t6_idle_hreadyout", HREADYOUT, 1);
        end
        // Active transfer type but not selected: still no APB activity
        HSEL = 1'b0; HTRANS = 2'b10;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("nosel_psel", PSEL, 0);
            chk("nosel_hresp", HRESP, 0);
        end
        HTRANS = 2'b00; PREADY = 1'b0;

        ahb_xfer(16'h2468, 1'b0, 64'h0, 8'hAA, 64'h0123_4567_89AB_CDEF, 0, 1'b0);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
